dm_cache_wb: RTL and testbench
==============================

// Module: dm_cache_wb
// PURPOSE
// - Parametrised direct-mapped, write-back, write-allocate cache between the CPU memory port and main memory.
// - Hit: one-cycle response. Miss: optional dirty-victim writeback, then a block refill, then completion.
// - All traffic is word-serial on the memory side, with a per-word readyM handshake.
// PARAMETERS
// - WORD_SIZE    16  data/address width in bits
// - LINES        4   number of cache lines; power of 2, >=2
// - BLOCK_WORDS  4   words per line; power of 2, >=2
// - Derived: OFF=log2(BLOCK_WORDS), IDX=log2(LINES), TAG=WORD_SIZE-IDX-OFF
// PORTS
// - clk       in   1          clock
// - reset_n   in   1          synchronous, active-low reset
// - readC     in   1          CPU read request; level, held until readyC
// - writeC    in   1          CPU write request; level, held until readyC
// - address   in   WORD_SIZE  CPU word address
// - data_in   in   WORD_SIZE  CPU write data
// - data_out  out  WORD_SIZE  CPU read data; valid while readyC=1
// - readyC    out  1          one-cycle completion pulse
// - readM     out  1          memory word read request
// - writeM    out  1          memory word write request
// - addressM  out  WORD_SIZE  memory word address
// - dataM_in  in   WORD_SIZE  memory read data; sampled when readyM=1
// - dataM_out out  WORD_SIZE  memory write data
// - readyM    in   1          memory word done; 1-cycle pulse, any latency
// - hit_cnt   out  WORD_SIZE  hit counter (see CONFIGURATION)
// - miss_cnt  out  WORD_SIZE  miss counter (see CONFIGURATION)
// BEHAVIOUR
// - Reset: all valid/dirty=0, FSM=IDLE, word counter=0.
// - Outputs at reset: readyC=readM=writeM=0, addressM=dataM_out=data_out=0, counters=0.
// - Reset mid-operation aborts any WB/FILL in the same edge; the partial line stays invalid.
// - Address split: tag=address[W-1:IDX+OFF], index=[IDX+OFF-1:OFF], offset=[OFF-1:0].
// - Request acceptance: IDLE accepts a request when readC|writeC. If both are high, treat as a write.
// - States: IDLE, WB, FILL, RESP.
// - IDLE, hit:
//   - read: load data_out.
//   - write: update the word, set dirty.
//   - -> RESP.
// - IDLE, miss with victim valid&dirty -> WB. Miss otherwise -> FILL.
// - WB:
//   - writeM=1, addressM={victim_tag,index,cnt}, dataM_out=victim word cnt.
//   - Each readyM: cnt++. Last word -> FILL with cnt=0.
// - FILL:
//   - readM=1, addressM={tag,index,cnt}.
//   - Each readyM: store dataM_in into word cnt, cnt++.
//   - Last word: tag written, valid=1, dirty=0, -> IDLE. The request is still held, so it now hits and completes through the hit path.
// - RESP: readyC=1 for exactly one cycle -> IDLE. The CPU must drop or change its request in the readyC cycle.
// - Latency: hit=1 cycle to readyC. Clean miss=BLOCK_WORDS readyM beats + 2. Dirty miss adds BLOCK_WORDS beats.
// - readM and writeM are never both 1. addressM is stable while a request is pending. Word counter wraps at BLOCK_WORDS.
// - readyM outside WB/FILL is ignored.
// CONFIGURATION
// - Macro CACHE_STATS_EN.
// - Defined:
//   - hit_cnt += 1 on every IDLE hit that is not the re-lookup after a FILL.
//   - miss_cnt += 1 on every IDLE miss.
//   - Both wrap modulo 2^WORD_SIZE.
// - Undefined: hit_cnt=miss_cnt=0 constantly; no counter flops are synthesised.
// TESTING
// - Post-reset read 0x0040, memory returns 0xA0..0xA3 at 0x0040..43:
//   - 4 readM beats, then data_out=0xA0 with readyC pulse.
//   - Re-read 0x0041: readyC 1 cycle later, data 0xA1, no readM.
// - Write 0x0042=0x1234 (hit), then read 0x0082 (same index, new tag):
//   - 4 writeM beats to 0x0040..43 carrying 0xA0,0xA1,0x1234,0xA3.
//   - Then 4 readM beats from 0x0080..83.
// - Write miss to 0x0100, data 0xBEEF:
//   - Refill 0x0100..03, then readyC.
//   - Later eviction writes 0xBEEF back to 0x0100.
// - readyM held off 5 cycles per beat: readM and addressM stay stable, no extra beats, readyC still pulses exactly once.
// - reset_n=0 during the 2nd FILL beat: outputs are 0 next edge; a re-read of the same address misses and refills.
// - CACHE_STATS_EN: the sequence miss, hit, hit, miss gives hit_cnt=2, miss_cnt=2. Without the macro both read 0.

Source files
------------

// File: rtl/dm_cache_wb.sv
// dm_cache_wb: direct-mapped, write-back, write-allocate cache between a CPU
// word port and a word-serial main-memory port.
//   hit        : the request completes through RESP one cycle after it is seen
//   clean miss : FILL a block word by word, then re-look-up (now a hit)
//   dirty miss : WB the victim block word by word, then FILL
// Optional macro CACHE_STATS_EN adds hit/miss counters. Without it hit_cnt
// and miss_cnt are tied to zero and no counter flops exist.
module dm_cache_wb #(
   parameter int WORD_SIZE   = 16,
   parameter int LINES       = 4,
   parameter int BLOCK_WORDS = 4
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 readC,
   input  logic                 writeC,
   input  logic [WORD_SIZE-1:0] address,
   input  logic [WORD_SIZE-1:0] data_in,
   output logic [WORD_SIZE-1:0] data_out,
   output logic                 readyC,
   output logic                 readM,
   output logic                 writeM,
   output logic [WORD_SIZE-1:0] addressM,
   input  logic [WORD_SIZE-1:0] dataM_in,
   output logic [WORD_SIZE-1:0] dataM_out,
   input  logic                 readyM,
   output logic [WORD_SIZE-1:0] hit_cnt,
   output logic [WORD_SIZE-1:0] miss_cnt
);

   // state  | meaning
   // IDLE   | waiting for a request; performs the tag lookup
   // WB     | writing the dirty victim block back, one word per readyM
   // FILL   | reading the requested block in, one word per readyM
   // RESP   | readyC pulse for one cycle
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WB   = 2'd1;
   localparam logic [1:0] S_FILL = 2'd2;
   localparam logic [1:0] S_RESP = 2'd3;

   localparam int OFF = $clog2(BLOCK_WORDS);
   localparam int IDX = $clog2(LINES);
   localparam int TAG = WORD_SIZE - IDX - OFF;
   localparam logic [OFF-1:0] LAST_WORD = OFF'(BLOCK_WORDS - 1);

   logic [1:0]           state;
   logic [OFF-1:0]       cnt;
   logic [LINES-1:0]     valid_q;
   logic [LINES-1:0]     dirty_q;
   logic [TAG-1:0]       tag_q  [LINES];
   logic [WORD_SIZE-1:0] data_q [LINES*BLOCK_WORDS];

   logic [TAG-1:0] req_tag;
   logic [IDX-1:0] req_idx;
   logic [OFF-1:0] req_off;
   logic           req;
   logic           req_wr;
   logic           hit;
   logic           victim_dirty;
   logic           last_word;
   logic           lookup;
   logic           fill_beat;
   logic           fill_done;

   assign req_tag = address[WORD_SIZE-1 -: TAG];
   assign req_idx = address[OFF +: IDX];
   assign req_off = address[0 +: OFF];

   // Both request lines high is treated as a write.
   assign req          = readC | writeC;
   assign req_wr       = writeC;
   assign hit          = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
   assign victim_dirty = valid_q[req_idx] && dirty_q[req_idx];
   assign last_word    = (cnt == LAST_WORD);
   assign lookup       = (state == S_IDLE) && req;
   assign fill_beat    = (state == S_FILL) && readyM;
   assign fill_done    = fill_beat && last_word;

   assign readyC = (state == S_RESP);
   assign readM  = (state == S_FILL);
   assign writeM = (state == S_WB);

   // Memory-side address and write data; zero whenever no beat is in progress.
   always_comb begin
      addressM  = '0;
      dataM_out = '0;
      if (state == S_WB) begin
         addressM  = {tag_q[req_idx], req_idx, cnt};
         dataM_out = data_q[{req_idx, cnt}];
      end else if (state == S_FILL) begin
         addressM  = {req_tag, req_idx, cnt};
      end
   end

   // Controller: lookup, writeback/refill sequencing, line status, read data.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state    <= S_IDLE;
         cnt      <= '0;
         valid_q  <= '0;
         dirty_q  <= '0;
         data_out <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (req) begin
                  cnt <= '0;
                  if (hit) begin
                     if (req_wr) dirty_q[req_idx] <= 1'b1;
                     else        data_out <= data_q[{req_idx, req_off}];
                     state <= S_RESP;
                  end else if (victim_dirty) begin
                     state <= S_WB;
                  end else begin
                     // The line is rewritten word by word; keep it invalid
                     // until the whole block has arrived.
                     valid_q[req_idx] <= 1'b0;
                     state            <= S_FILL;
                  end
               end
            end
            S_WB: begin
               if (readyM) begin
                  cnt <= cnt + 1'b1;
                  if (last_word) begin
                     valid_q[req_idx] <= 1'b0;
                     dirty_q[req_idx] <= 1'b0;
                     state            <= S_FILL;
                  end
               end
            end
            S_FILL: begin
               if (readyM) begin
                  cnt <= cnt + 1'b1;
                  if (last_word) begin
                     valid_q[req_idx] <= 1'b1;
                     dirty_q[req_idx] <= 1'b0;
                     state            <= S_IDLE;
                  end
               end
            end
            S_RESP: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   // Line data: CPU write hits and refill words. Held off during reset so an
   // aborted refill cannot touch the array.
   always_ff @(posedge clk) begin
      if (reset_n) begin
         if (lookup && hit && req_wr) begin
            data_q[{req_idx, req_off}] <= data_in;
         end else if (fill_beat) begin
            data_q[{req_idx, cnt}] <= dataM_in;
         end
      end
   end

   // Tag store, written once the refilled block is complete.
   always_ff @(posedge clk) begin
      if (reset_n && fill_done) begin
         tag_q[req_idx] <= req_tag;
      end
   end

`ifdef CACHE_STATS_EN
   logic                 relook_q;
   logic [WORD_SIZE-1:0] hit_q;
   logic [WORD_SIZE-1:0] miss_q;

   // Hit/miss statistics; the hit that completes a refilled request is not
   // counted because that request was already counted as a miss.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         relook_q <= 1'b0;
         hit_q    <= '0;
         miss_q   <= '0;
      end else begin
         if (fill_done)              relook_q <= 1'b1;
         else if (state == S_IDLE)   relook_q <= 1'b0;
         if (lookup) begin
            if (!hit)                miss_q <= miss_q + 1'b1;
            else if (!relook_q)      hit_q  <= hit_q + 1'b1;
         end
      end
   end

   assign hit_cnt  = hit_q;
   assign miss_cnt = miss_q;
`else
   assign hit_cnt  = '0;
   assign miss_cnt = '0;
`endif

endmodule

// File: tb/tb_dm_cache_wb.sv
// tb_dm_cache_wb: drives dm_cache_wb with directed and random CPU traffic
// against a memory responder of adjustable latency. A reference model of
// line state (valid/tag/dirty), backing memory and the CPU-visible image
// predicts read data, the exact memory beat sequence and the counters.
module tb_dm_cache_wb;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        readC;
   logic        writeC;
   logic [15:0] address;
   logic [15:0] data_in;
   logic [15:0] data_out;
   logic        readyC;
   logic        readM;
   logic        writeM;
   logic [15:0] addressM;
   logic [15:0] dataM_in;
   logic [15:0] dataM_out;
   logic        readyM;
   logic [15:0] hit_cnt;
   logic [15:0] miss_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   dm_cache_wb #(.WORD_SIZE(16), .LINES(4), .BLOCK_WORDS(4)) dut (
      .clk(clk), .reset_n(reset_n), .readC(readC), .writeC(writeC),
      .address(address), .data_in(data_in), .data_out(data_out),
      .readyC(readyC), .readM(readM), .writeM(writeM), .addressM(addressM),
      .dataM_in(dataM_in), .dataM_out(dataM_out), .readyM(readyM),
      .hit_cnt(hit_cnt), .miss_cnt(miss_cnt));

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   logic [15:0] mem    [logic [15:0]];   // backing memory contents
   logic [15:0] shadow [logic [15:0]];   // CPU writes not yet lost to reset
   bit          rv [4];
   bit          rd [4];
   logic [11:0] rt [4];
   int          exp_hits;
   int          exp_misses;

   function automatic logic [15:0] dram(input logic [15:0] a);
      if (mem.exists(a)) return mem[a];
      return a ^ 16'h5A5A;
   endfunction

   function automatic logic [15:0] view(input logic [15:0] a);
      if (shadow.exists(a)) return shadow[a];
      return dram(a);
   endfunction

   function automatic void model_reset();
      for (int i = 0; i < 4; i++) begin
         rv[i] = 1'b0;
         rd[i] = 1'b0;
         rt[i] = '0;
      end
      shadow.delete();
      exp_hits   = 0;
      exp_misses = 0;
   endfunction

   // ---------------- memory responder ----------------
   int          lat = 0;
   bit          resp_en = 1'b1;
   bit          force_rdy = 1'b0;
   int          wait_cnt = 0;
   bit          in_beat = 1'b0;
   logic [15:0] beat_addr = '0;
   int          stab_err = 0;
   int          both_err = 0;
   bit          log_wr   [$];
   logic [15:0] log_addr [$];
   logic [15:0] log_data [$];

   initial begin
      readyM   = 1'b0;
      dataM_in = '0;
      forever begin
         @(negedge clk);
         if (readM && writeM) both_err++;
         if (!resp_en) begin
            readyM   = force_rdy;
            wait_cnt = 0;
            in_beat  = 1'b0;
         end else if (readyM) begin
            readyM   = 1'b0;
            dataM_in = 16'($urandom);
         end else if (readM || writeM) begin
            if (in_beat && addressM !== beat_addr) stab_err++;
            if (!in_beat) begin
               in_beat   = 1'b1;
               beat_addr = addressM;
            end
            if (wait_cnt >= lat) begin
               readyM = 1'b1;
               log_wr.push_back(writeM);
               log_addr.push_back(addressM);
               if (writeM) begin
                  log_data.push_back(dataM_out);
               end else begin
                  dataM_in = dram(addressM);
                  log_data.push_back(dataM_in);
               end
               wait_cnt = 0;
               in_beat  = 1'b0;
            end else begin
               wait_cnt++;
               dataM_in = 16'($urandom);
            end
         end else begin
            wait_cnt = 0;
            in_beat  = 1'b0;
            dataM_in = 16'($urandom);
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic do_reset();
      @(negedge clk);
      reset_n = 1'b0;
      readC   = 1'b0;
      writeC  = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      model_reset();
   endtask

   // One CPU transaction; predicts beats, data and latency from the model.
   task automatic cpu_access(input bit rd_lvl, input bit wr_lvl,
                             input logic [15:0] a, input logic [15:0] d,
                             output logic [15:0] got, output int nbeats);
      logic [1:0]  idx;
      logic [11:0] t;
      logic [15:0] va;
      logic [15:0] exp_rd;
      bit          exp_hit;
      bit          ew [$];
      logic [15:0] ea [$];
      logic [15:0] ed [$];
      int          base, cyc, rdy_cyc, last_beat, pulses, n;
      idx     = a[3:2];
      t       = a[15:4];
      exp_hit = rv[idx] && (rt[idx] == t);
      if (exp_hit) begin
         exp_hits++;
      end else begin
         exp_misses++;
         if (rv[idx] && rd[idx]) begin
            for (int w = 0; w < 4; w++) begin
               va = {rt[idx], idx, 2'(w)};
               ew.push_back(1'b1);
               ea.push_back(va);
               ed.push_back(view(va));
               mem[va] = view(va);
            end
         end
         for (int w = 0; w < 4; w++) begin
            va = {t, idx, 2'(w)};
            ew.push_back(1'b0);
            ea.push_back(va);
            ed.push_back(dram(va));
         end
         rv[idx] = 1'b1;
         rt[idx] = t;
         rd[idx] = 1'b0;
      end
      if (wr_lvl) begin
         shadow[a] = d;
         rd[idx]   = 1'b1;
      end
      exp_rd = view(a);

      base = log_addr.size();
      @(negedge clk);
      address = a;
      data_in = d;
      readC   = rd_lvl;
      writeC  = wr_lvl;
      cyc = 0; rdy_cyc = 0; last_beat = 0; pulses = 0; got = '0;
      while (rdy_cyc == 0 && cyc < 3000) begin
         @(posedge clk);
         #1;
         cyc++;
         if (readyM) last_beat = cyc;
         if (readyC) begin
            rdy_cyc = cyc;
            got     = data_out;
            pulses++;
            readC   = 1'b0;
            writeC  = 1'b0;
         end
      end
      @(posedge clk);
      #1;
      if (readyC) pulses++;
      readC  = 1'b0;
      writeC = 1'b0;
      nbeats = log_addr.size() - base;

      n_checks++;
      if (rdy_cyc == 0) begin
         n_fail++;
         $display("FAIL access_timeout addr=%h: no readyC within %0d cycles", a, cyc);
      end else if (pulses !== 1) begin
         n_fail++;
         $display("FAIL readyC_pulses addr=%h: got %0d, expected 1", a, pulses);
      end
      if (!wr_lvl) begin
         n_checks++;
         if (got !== exp_rd) begin
            n_fail++;
            $display("FAIL read_data addr=%h: got %h, expected %h", a, got, exp_rd);
         end
      end
      n_checks++;
      if (exp_hit && rdy_cyc != 1) begin
         n_fail++;
         $display("FAIL hit_latency addr=%h: got %0d cycles, expected 1", a, rdy_cyc);
      end else if (!exp_hit && rdy_cyc != last_beat + 1) begin
         n_fail++;
         $display("FAIL miss_latency addr=%h: readyC %0d cycles after last beat, expected 1",
                  a, rdy_cyc - last_beat);
      end
      n_checks++;
      if (nbeats != ea.size()) begin
         n_fail++;
         $display("FAIL beat_count addr=%h: got %0d, expected %0d", a, nbeats, ea.size());
      end
      n = (nbeats < ea.size()) ? nbeats : ea.size();
      for (int i = 0; i < n; i++) begin
         n_checks++;
         if (log_wr[base+i] !== ew[i] || log_addr[base+i] !== ea[i] || log_data[base+i] !== ed[i]) begin
            n_fail++;
            $display("FAIL beat_%0d addr=%h: got wr=%0d %h/%h, expected wr=%0d %h/%h", i, a,
                     log_wr[base+i], log_addr[base+i], log_data[base+i], ew[i], ea[i], ed[i]);
         end
      end
   endtask

   task automatic check_stats(input string name);
      int eh, em;
`ifdef CACHE_STATS_EN
      eh = exp_hits;
      em = exp_misses;
`else
      eh = 0;
      em = 0;
`endif
      @(negedge clk);
      n_checks++;
      if (hit_cnt !== 16'(eh) || miss_cnt !== 16'(em)) begin
         n_fail++;
         $display("FAIL %s: hit_cnt=%0d miss_cnt=%0d, expected %0d/%0d", name, hit_cnt, miss_cnt, eh, em);
      end
   endtask

   task automatic test_reset();
      do_reset();
      @(negedge clk);
      n_checks++; if (readyC !== 1'b0)    begin n_fail++; $display("FAIL rst_readyC: got %b, expected 0", readyC); end
      n_checks++; if (readM !== 1'b0)     begin n_fail++; $display("FAIL rst_readM: got %b, expected 0", readM); end
      n_checks++; if (writeM !== 1'b0)    begin n_fail++; $display("FAIL rst_writeM: got %b, expected 0", writeM); end
      n_checks++; if (addressM !== 16'h0) begin n_fail++; $display("FAIL rst_addressM: got %h, expected 0", addressM); end
      n_checks++; if (dataM_out !== 16'h0) begin n_fail++; $display("FAIL rst_dataM_out: got %h, expected 0", dataM_out); end
      n_checks++; if (data_out !== 16'h0) begin n_fail++; $display("FAIL rst_data_out: got %h, expected 0", data_out); end
      n_checks++; if (hit_cnt !== 16'h0)  begin n_fail++; $display("FAIL rst_hit_cnt: got %h, expected 0", hit_cnt); end
      n_checks++; if (miss_cnt !== 16'h0) begin n_fail++; $display("FAIL rst_miss_cnt: got %h, expected 0", miss_cnt); end
   endtask

   task automatic test_directed();
      logic [15:0] got;
      int nb;
      lat = 0;
      cpu_access(1'b1, 1'b0, 16'h0040, 16'h0000, got, nb);
      n_checks++;
      if (got !== 16'h00A0 || nb != 4) begin
         n_fail++;
         $display("FAIL dir_first_read: got %h/%0d beats, expected 00a0/4", got, nb);
      end
      cpu_access(1'b1, 1'b0, 16'h0041, 16'h0000, got, nb);
      n_checks++;
      if (got !== 16'h00A1 || nb != 0) begin
         n_fail++;
         $display("FAIL dir_reread: got %h/%0d beats, expected 00a1/0", got, nb);
      end
      cpu_access(1'b0, 1'b1, 16'h0042, 16'h1234, got, nb);
      cpu_access(1'b1, 1'b0, 16'h0082, 16'h0000, got, nb);
      n_checks++;
      if (nb != 8) begin
         n_fail++;
         $display("FAIL dir_dirty_evict: got %0d beats, expected 8", nb);
      end
      cpu_access(1'b0, 1'b1, 16'h0100, 16'hBEEF, got, nb);
      cpu_access(1'b1, 1'b0, 16'h0100, 16'h0000, got, nb);
      n_checks++;
      if (got !== 16'hBEEF) begin
         n_fail++;
         $display("FAIL dir_write_alloc: got %h, expected beef", got);
      end
      cpu_access(1'b1, 1'b0, 16'h0000, 16'h0000, got, nb);
   endtask

   task automatic test_both_high();
      logic [15:0] got;
      int nb;
      cpu_access(1'b1, 1'b1, 16'h0055, 16'hC0DE, got, nb);
      cpu_access(1'b1, 1'b0, 16'h0055, 16'h0000, got, nb);
   endtask

   task automatic test_slow_mem();
      logic [15:0] got;
      int nb;
      lat = 5;
      cpu_access(1'b0, 1'b1, 16'h0204, 16'h7777, got, nb);
      cpu_access(1'b1, 1'b0, 16'h0304, 16'h0000, got, nb);
      cpu_access(1'b1, 1'b0, 16'h0206, 16'h0000, got, nb);
      n_checks++;
      if (stab_err != 0 || both_err != 0) begin
         n_fail++;
         $display("FAIL slow_mem_stability: addr changes=%0d both_high=%0d, expected 0/0", stab_err, both_err);
      end
      lat = 0;
   endtask

   task automatic test_spurious_readym();
      logic [15:0] got;
      int nb;
      @(negedge clk);
      resp_en   = 1'b0;
      force_rdy = 1'b1;
      repeat (3) @(negedge clk);
      force_rdy = 1'b0;
      @(negedge clk);
      n_checks++;
      if (readM !== 1'b0 || writeM !== 1'b0 || readyC !== 1'b0) begin
         n_fail++;
         $display("FAIL spurious_readyM: readM=%b writeM=%b readyC=%b, expected 000", readM, writeM, readyC);
      end
      resp_en = 1'b1;
      cpu_access(1'b1, 1'b0, 16'h0206, 16'h0000, got, nb);
      cpu_access(1'b1, 1'b0, 16'h0408, 16'h0000, got, nb);
   endtask

   task automatic test_reset_mid_fill();
      logic [15:0] got;
      int nb, base, cyc;
      bit seen;
      do_reset();
      lat  = 2;
      base = log_addr.size();
      @(negedge clk);
      address = 16'h0300;
      data_in = 16'h0000;
      readC   = 1'b1;
      cyc  = 0;
      seen = 1'b0;
      while (!seen && cyc < 200) begin
         @(posedge clk);
         #1;
         cyc++;
         if (log_addr.size() == base + 1 && !readyM && readM && addressM == 16'h0301) seen = 1'b1;
      end
      n_checks++;
      if (!seen) begin
         n_fail++;
         $display("FAIL midfill_wait: second fill beat not reached in %0d cycles", cyc);
      end
      @(negedge clk);
      reset_n = 1'b0;
      @(posedge clk);
      #1;
      n_checks++;
      if (readM !== 1'b0 || writeM !== 1'b0 || readyC !== 1'b0 || addressM !== 16'h0 || data_out !== 16'h0) begin
         n_fail++;
         $display("FAIL midfill_reset_outputs: readM=%b writeM=%b readyC=%b addressM=%h data_out=%h, expected all 0",
                  readM, writeM, readyC, addressM, data_out);
      end
      readC = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      model_reset();
      cpu_access(1'b1, 1'b0, 16'h0300, 16'h0000, got, nb);
      n_checks++;
      if (nb != 4) begin
         n_fail++;
         $display("FAIL midfill_reread: got %0d beats, expected 4", nb);
      end
      lat = 0;
   endtask

   task automatic test_stats();
      logic [15:0] got;
      int nb;
      do_reset();
      cpu_access(1'b1, 1'b0, 16'h0010, 16'h0000, got, nb);
      cpu_access(1'b1, 1'b0, 16'h0011, 16'h0000, got, nb);
      cpu_access(1'b0, 1'b1, 16'h0012, 16'h4321, got, nb);
      cpu_access(1'b1, 1'b0, 16'h0020, 16'h0000, got, nb);
      @(negedge clk);
      n_checks++;
`ifdef CACHE_STATS_EN
      if (hit_cnt !== 16'd2 || miss_cnt !== 16'd2) begin
         n_fail++;
         $display("FAIL stats_seq: hit_cnt=%0d miss_cnt=%0d, expected 2/2", hit_cnt, miss_cnt);
      end
`else
      if (hit_cnt !== 16'd0 || miss_cnt !== 16'd0) begin
         n_fail++;
         $display("FAIL stats_seq: hit_cnt=%0d miss_cnt=%0d, expected 0/0", hit_cnt, miss_cnt);
      end
`endif
   endtask

   task automatic test_random();
      logic [15:0] got;
      logic [15:0] a;
      int nb, kind;
      do_reset();
      for (int i = 0; i < 250; i++) begin
         lat  = $urandom_range(0, 3);
         a    = 16'($urandom_range(0, 127));
         if ($urandom_range(0, 7) == 0) a = a | 16'hF000;
         kind = $urandom_range(0, 5);
         if (kind < 3)       cpu_access(1'b1, 1'b0, a, 16'h0000, got, nb);
         else if (kind < 5)  cpu_access(1'b0, 1'b1, a, 16'($urandom), got, nb);
         else                cpu_access(1'b1, 1'b1, a, 16'($urandom), got, nb);
      end
      check_stats("random_stats");
      lat = 0;
   endtask

   initial begin
      reset_n = 1'b0;
      readC   = 1'b0;
      writeC  = 1'b0;
      address = '0;
      data_in = '0;
      for (int i = 0; i < 4; i++) mem[16'h0040 + 16'(i)] = 16'h00A0 + 16'(i);
      model_reset();
      test_reset();
      test_directed();
      check_stats("directed_stats");
      test_both_high();
      test_slow_mem();
      test_spurious_readym();
      test_reset_mid_fill();
      test_stats();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
